// File: rtl/wfc_pkg.sv
// ---------------------------------------------------------------------------
// wfc_pkg
// Shared definitions for the weight fetch controller:
//   - wfc_state_e    : controller state encoding (IDLE/FETCH/DRAIN/DONE)
//   - FIFO_DEPTH     : number of output buffer entries (also the read credit)
//   - fifo_cnt_width : width needed to hold an occupancy of 0..depth
// ---------------------------------------------------------------------------
package wfc_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } wfc_state_e;

  localparam int FIFO_DEPTH = 4;

  // Occupancy counter width: must represent the full value 'depth', not just depth-1.
  function automatic int fifo_cnt_width(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/wfc_if.sv
// ---------------------------------------------------------------------------
// wfc_if
// Weight word stream between the fetch controller and the PE array.
//   w_valid : word available (source -> sink)
//   w_ready : sink accepts word (sink -> source)
//   w_data  : weight word
//   w_last  : final word of the command
// Modports: master = stream source (controller), slave = stream sink.
// ---------------------------------------------------------------------------
interface wfc_if #(
  parameter int DATA_WIDTH = 32
);
  logic                  w_valid;
  logic                  w_ready;
  logic [DATA_WIDTH-1:0] w_data;
  logic                  w_last;

  modport master (output w_valid, output w_data, output w_last, input w_ready);
  modport slave  (input w_valid, input w_data, input w_last, output w_ready);
endinterface

// File: rtl/wfc_fifo.sv
// ---------------------------------------------------------------------------
// wfc_fifo
// Synchronous FIFO_DEPTH-entry buffer for {last, weight} words.
// Ports:
//   clk, rst : clock, asynchronous active-high reset
//   push/din : write request and data (accepted if not full, or full with pop)
//   pop/dout : read request; dout shows the head entry
//   full, empty, count : occupancy status
// A push and pop in the same cycle on a full FIFO both take effect.
// ---------------------------------------------------------------------------
module wfc_fifo
  import wfc_pkg::*;
#(
  parameter int WIDTH = 33
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic                                  push,
  input  logic [WIDTH-1:0]                      din,
  input  logic                                  pop,
  output logic [WIDTH-1:0]                      dout,
  output logic                                  full,
  output logic                                  empty,
  output logic [fifo_cnt_width(FIFO_DEPTH)-1:0] count
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = fifo_cnt_width(FIFO_DEPTH);

  logic [WIDTH-1:0] mem_r [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr_r;
  logic [PTR_W-1:0] rd_ptr_r;
  logic [CNT_W-1:0] count_r;
  logic             do_push_s;
  logic             do_pop_s;

  assign full      = (count_r == CNT_W'(FIFO_DEPTH));
  assign empty     = (count_r == {CNT_W{1'b0}});
  assign count     = count_r;
  assign dout      = mem_r[rd_ptr_r];
  assign do_pop_s  = pop && !empty;
  assign do_push_s = push && (!full || do_pop_s);

  // Storage, pointers and occupancy counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem_r[i] <= {WIDTH{1'b0}};
      end
      wr_ptr_r <= {PTR_W{1'b0}};
      rd_ptr_r <= {PTR_W{1'b0}};
      count_r  <= {CNT_W{1'b0}};
    end else begin
      if (do_push_s) begin
        mem_r[wr_ptr_r] <= din;
        wr_ptr_r        <= wr_ptr_r + PTR_W'(1'b1);
      end
      if (do_pop_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_W'(1'b1);
      end
      case ({do_push_s, do_pop_s})
        2'b10:   count_r <= count_r + CNT_W'(1'b1);
        2'b01:   count_r <= count_r - CNT_W'(1'b1);
        default: count_r <= count_r;
      endcase
    end
  end

endmodule

// File: rtl/weight_fetch_ctrl.sv
// ---------------------------------------------------------------------------
// weight_fetch_ctrl
// Sequences reads from one of NUM_BLOCKS weight ROMs (one-cycle registered
// read latency) and streams the words to the PE array. Reads are issued only
// while buffered + in-flight words < FIFO_DEPTH, so the ROM never runs ahead
// of the consumer.
// Ports:
//   clk, rst      : clock, asynchronous active-high reset
//   start         : command strobe (honoured in IDLE only)
//   blk_sel       : ROM select, sampled with start
//   base_addr     : first word address, sampled with start
//   word_cnt      : words per pass (0 = empty command), sampled with start
//   rep_cnt       : passes minus one (present only with WFC_REPEAT_EN)
//   rom_en        : one-hot ROM read enable
//   rom_addr      : ROM read address (shared)
//   rom_data      : concatenated ROM outputs, block i at [i*DATA_WIDTH +: DATA_WIDTH]
//   w             : weight stream source (wfc_if.master)
//   busy          : high in FETCH and DRAIN
//   done          : one-cycle completion pulse
// Build option: define WFC_REPEAT_EN to enable multi-pass replay via rep_cnt.
// ---------------------------------------------------------------------------
module weight_fetch_ctrl
  import wfc_pkg::*;
#(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 32,
  parameter int NUM_BLOCKS = 4,
  parameter int REP_WIDTH  = 8
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             start,
  input  logic [$clog2(NUM_BLOCKS)-1:0]    blk_sel,
  input  logic [ADDR_WIDTH-1:0]            base_addr,
  input  logic [ADDR_WIDTH-1:0]            word_cnt,
`ifdef WFC_REPEAT_EN
  input  logic [REP_WIDTH-1:0]             rep_cnt,
`endif
  output logic [NUM_BLOCKS-1:0]            rom_en,
  output logic [ADDR_WIDTH-1:0]            rom_addr,
  input  logic [NUM_BLOCKS*DATA_WIDTH-1:0] rom_data,
  wfc_if.master                            w,
  output logic                             busy,
  output logic                             done
);

  localparam int BLK_W = $clog2(NUM_BLOCKS);
  localparam int CNT_W = fifo_cnt_width(FIFO_DEPTH);
  localparam int FW    = DATA_WIDTH + 1;

  wfc_state_e            state_r, state_n;
  logic [BLK_W-1:0]      blk_r;
  logic [ADDR_WIDTH-1:0] base_r, cnt_r, idx_r;
  logic [REP_WIDTH-1:0]  rep_r, pass_r, rep_in_s;

  logic [BLK_W-1:0]      cur_blk_s;
  logic [ADDR_WIDTH-1:0] cur_base_s, cur_cnt_s, cur_idx_s;
  logic [REP_WIDTH-1:0]  cur_rep_s, cur_pass_s;
  logic                  wrap_s, final_s, issue_s, load_s;
  logic                  credit_ok_s, drain_done_s, pop_s;
  logic [CNT_W:0]        occ_s;
  logic [NUM_BLOCKS-1:0] rom_en_n_s;

  logic [NUM_BLOCKS-1:0] rom_en_r;
  logic [ADDR_WIDTH-1:0] rom_addr_r;
  logic                  s1_v_r, s1_last_r, s2_v_r, s2_last_r;
  logic [BLK_W-1:0]      s1_blk_r, s2_blk_r;
  logic                  busy_r, done_r;

  logic                  fifo_push_s, fifo_full_s, fifo_empty_s;
  logic [FW-1:0]         fifo_din_s, fifo_dout_s;
  logic [CNT_W-1:0]      fifo_count_s;

`ifdef WFC_REPEAT_EN
  assign rep_in_s = rep_cnt;
`else
  assign rep_in_s = {REP_WIDTH{1'b0}};
`endif

  // In IDLE the command comes straight from the ports so the first read can
  // issue on the same edge that accepts start; afterwards from the latches.
  always_comb begin
    if (state_r == IDLE) begin
      cur_blk_s  = blk_sel;
      cur_base_s = base_addr;
      cur_cnt_s  = word_cnt;
      cur_rep_s  = rep_in_s;
      cur_idx_s  = {ADDR_WIDTH{1'b0}};
      cur_pass_s = {REP_WIDTH{1'b0}};
    end else begin
      cur_blk_s  = blk_r;
      cur_base_s = base_r;
      cur_cnt_s  = cnt_r;
      cur_rep_s  = rep_r;
      cur_idx_s  = idx_r;
      cur_pass_s = pass_r;
    end
  end

  assign wrap_s  = (cur_idx_s == (cur_cnt_s - ADDR_WIDTH'(1'b1)));
  assign final_s = wrap_s && (cur_pass_s == cur_rep_s);

  // Every word not yet handed to the consumer holds one credit.
  assign occ_s        = {1'b0, fifo_count_s} + (CNT_W+1)'(s1_v_r) + (CNT_W+1)'(s2_v_r);
  assign credit_ok_s  = (occ_s < (CNT_W+1)'(FIFO_DEPTH));
  assign pop_s        = !fifo_empty_s && w.w_ready;
  // Leave DRAIN on the edge of the final handshake so done follows it directly.
  assign drain_done_s = !s1_v_r && !s2_v_r &&
                        (fifo_empty_s || ((fifo_count_s == CNT_W'(1'b1)) && pop_s));

  // Next-state and read-issue decisions.
  always_comb begin
    state_n = state_r;
    issue_s = 1'b0;
    load_s  = 1'b0;
    case (state_r)
      IDLE: begin
        if (start) begin
          load_s = 1'b1;
          if (word_cnt == {ADDR_WIDTH{1'b0}}) begin
            state_n = DONE;
          end else begin
            issue_s = 1'b1;
            state_n = final_s ? DRAIN : FETCH;
          end
        end else begin
          state_n = IDLE;
        end
      end
      FETCH: begin
        if (credit_ok_s) begin
          issue_s = 1'b1;
          state_n = final_s ? DRAIN : FETCH;
        end else begin
          state_n = FETCH;
        end
      end
      DRAIN:   state_n = drain_done_s ? DONE : DRAIN;
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // One-hot enable for the selected ROM on an issuing cycle.
  always_comb begin
    rom_en_n_s = {NUM_BLOCKS{1'b0}};
    for (int i = 0; i < NUM_BLOCKS; i++) begin
      rom_en_n_s[i] = issue_s && (cur_blk_s == BLK_W'(i));
    end
  end

  // State register with registered busy/done decoded from the next state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= IDLE;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
    end else begin
      state_r <= state_n;
      busy_r  <= (state_n == FETCH) || (state_n == DRAIN);
      done_r  <= (state_n == DONE);
    end
  end

  // Command latches and word/pass counters; idx wraps to 0 at each pass end.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      blk_r  <= {BLK_W{1'b0}};
      base_r <= {ADDR_WIDTH{1'b0}};
      cnt_r  <= {ADDR_WIDTH{1'b0}};
      rep_r  <= {REP_WIDTH{1'b0}};
      idx_r  <= {ADDR_WIDTH{1'b0}};
      pass_r <= {REP_WIDTH{1'b0}};
    end else begin
      if (load_s) begin
        blk_r  <= blk_sel;
        base_r <= base_addr;
        cnt_r  <= word_cnt;
        rep_r  <= rep_in_s;
      end
      if (issue_s) begin
        if (wrap_s) begin
          idx_r  <= {ADDR_WIDTH{1'b0}};
          pass_r <= cur_pass_s + REP_WIDTH'(1'b1);
        end else begin
          idx_r  <= cur_idx_s + ADDR_WIDTH'(1'b1);
          pass_r <= cur_pass_s;
        end
      end
    end
  end

  // Read pipeline: stage 1 = ROM request, stage 2 = ROM output register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rom_en_r   <= {NUM_BLOCKS{1'b0}};
      rom_addr_r <= {ADDR_WIDTH{1'b0}};
      s1_v_r     <= 1'b0;
      s1_blk_r   <= {BLK_W{1'b0}};
      s1_last_r  <= 1'b0;
      s2_v_r     <= 1'b0;
      s2_blk_r   <= {BLK_W{1'b0}};
      s2_last_r  <= 1'b0;
    end else begin
      rom_en_r <= rom_en_n_s;
      if (issue_s) begin
        rom_addr_r <= cur_base_s + cur_idx_s;
      end
      s1_v_r    <= issue_s;
      s1_blk_r  <= cur_blk_s;
      s1_last_r <= issue_s && final_s;
      s2_v_r    <= s1_v_r;
      s2_blk_r  <= s1_blk_r;
      s2_last_r <= s1_last_r;
    end
  end

  // Credits guarantee space; the full check only keeps the FIFO self-consistent.
  assign fifo_push_s = s2_v_r && (!fifo_full_s || pop_s);
  assign fifo_din_s  = {s2_last_r, rom_data[s2_blk_r*DATA_WIDTH +: DATA_WIDTH]};

  wfc_fifo #(
    .WIDTH (FW)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (fifo_push_s),
    .din   (fifo_din_s),
    .pop   (pop_s),
    .dout  (fifo_dout_s),
    .full  (fifo_full_s),
    .empty (fifo_empty_s),
    .count (fifo_count_s)
  );

  assign rom_en    = rom_en_r;
  assign rom_addr  = rom_addr_r;
  assign busy      = busy_r;
  assign done      = done_r;
  // Head entry is only meaningful while valid; show zeros otherwise.
  assign w.w_valid = !fifo_empty_s;
  assign w.w_data  = fifo_empty_s ? {DATA_WIDTH{1'b0}} : fifo_dout_s[DATA_WIDTH-1:0];
  assign w.w_last  = !fifo_empty_s && fifo_dout_s[DATA_WIDTH];

endmodule

// File: doc/weight_fetch_ctrl.md
# weight_fetch_ctrl

Sequencer for the per-block convolution weight ROMs. On a start command it issues enable/address reads to the selected ROM, absorbs the ROM's one-cycle registered read latency, and delivers weight words to the PE array over a valid/ready stream. Backpressure is handled with a small credit-limited output FIFO, so the ROM is never read faster than the consumer drains.

## Interface
Parameters:
- ADDR_WIDTH, 8, ROM address width, shared by all block ROMs
- DATA_WIDTH, 32, weight word width
- NUM_BLOCKS, 4, number of weight ROMs selectable
- REP_WIDTH, 8, repeat-count width (used only with WFC_REPEAT_EN)

Ports:
- clk  in  1  single clock, rising edge
- rst  in  1  asynchronous, active-high reset
- start  in  1  command strobe, accepted only in IDLE
- blk_sel  in  $clog2(NUM_BLOCKS)  ROM to read, sampled with start
- base_addr  in  ADDR_WIDTH  first word address, sampled with start
- word_cnt  in  ADDR_WIDTH  words per pass, sampled with start; 0 = empty command
- rep_cnt  in  REP_WIDTH  passes minus one, sampled with start (WFC_REPEAT_EN only)
- rom_en  out  NUM_BLOCKS  one-hot read enable, bit blk_sel
- rom_addr  out  ADDR_WIDTH  read address, common to all ROMs
- rom_data  in  NUM_BLOCKS*DATA_WIDTH  concatenated ROM outputs, block i at [i*DATA_WIDTH +: DATA_WIDTH]
- w_valid  out  1  weight word available
- w_ready  in  1  consumer accepts word
- w_data  out  DATA_WIDTH  weight word
- w_last  out  1  final word of command
- busy  out  1  command in progress
- done  out  1  one-cycle completion pulse

## Operation
- States: IDLE, FETCH, DRAIN, DONE.
- IDLE: start=1 latches the command and moves to FETCH; word_cnt=0 moves directly to DONE.
- FETCH: a read issues when FIFO occupancy + in-flight reads < 4. Issue sets rom_en one-hot and rom_addr = base_addr + idx, using mod-2^ADDR_WIDTH wrap. idx then increments.
- After word_cnt issues (× passes), move to DRAIN.
- The read pipeline has two in-flight stages: the registered rom_en/rom_addr, then the ROM output register. In-flight tag = valid bit + blk_sel + last flag.
- Pipeline stage 2 writes rom_data[blk_sel] into the FIFO along with the last flag.
- DRAIN: wait until the FIFO is empty and nothing is in flight, then go to DONE.
- DONE: done=1 for one cycle, then return to IDLE.
- busy=1 in FETCH and DRAIN only.
- start outside IDLE is ignored.
- w_last=1 only with the final word of the final pass.
- Stream rule: once w_valid=1, w_data and w_last hold stable until w_valid && w_ready.

## Timing
- Reset values: rom_en=0, rom_addr=0, w_valid=0, w_data=0, w_last=0, busy=0, done=0; state=IDLE; FIFO empty; in-flight cleared.
- Reset mid-command aborts it with no done pulse; the ROM's stale output is discarded.
- Latency: start sampled at edge 0 → rom_en high after edge 0 → ROM captures at edge 1 → FIFO write at edge 2 → w_valid high after edge 2.
- Throughput: one word per cycle with w_ready held high.
- With w_ready=0, at most 4 words are buffered and rom_en drops once the credits are exhausted.
- FIFO full with simultaneous push and pop: both occur and occupancy is unchanged.
- done is asserted the cycle after the last handshake; busy drops at that same edge.

## Configuration
- WFC_REPEAT_EN defined: rep_cnt is honoured. The address sequence replays (rep_cnt+1) times, idx resets to 0 at each pass boundary, and w_last marks only the final pass.
- WFC_REPEAT_EN undefined: the rep_cnt port is absent and exactly one pass runs.

## Structure
- Package wfc_pkg holds: the state enum (IDLE/FETCH/DRAIN/DONE), FIFO_DEPTH=4, and a helper for the FIFO count width.
- Sub-module wfc_fifo: synchronous 4-entry FIFO, (DATA_WIDTH+1) bits wide, with async-high reset, push/pop/full/empty/count. The controller, issue credit logic and in-flight pipeline stay in the top.

## Test plan
- blk_sel=2, base=0x10, cnt=5, w_ready=1 → rom_en=4'b0100, addresses 0x10..0x14, first w_valid 2 cycles after start, 5 words back-to-back, w_last on the 5th, done one cycle later.
- cnt=8 with w_ready=0 for 10 cycles → exactly 4 words buffered, rom_en low once credits are exhausted; releasing w_ready yields all 8 words in order with no loss or duplication.
- base=0xFE, cnt=4 → addresses 0xFE, 0xFF, 0x00, 0x01.
- cnt=0 → no rom_en, no w_valid, done pulse one cycle after start.
- rst asserted mid-FETCH at word 3 → all outputs at reset values immediately; a new start then runs cleanly from base.
- WFC_REPEAT_EN, cnt=3, rep_cnt=1 → 6 words with address pattern b, b+1, b+2, b, b+1, b+2; w_last only on the 6th; start pulses while busy are ignored.
